// File: rtl/approx_seq_multiply_unit.sv
// Sequential radix-2^BITS_PER_CYCLE sign-magnitude multiplier with acc low columns truncated plus half-ULP compensation.
// Latency STEPS cycles (zero operand: done on accept); accepts only in IDLE, holds result in DONE until out_ready.
module approx_seq_multiply_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int ACC_W          = $clog2(2*WIDTH)+1
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 signed_a,
  input  logic                 signed_b,
  input  logic [ACC_W-1:0]     acc,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int PW    = 2*WIDTH;
  localparam int STEPS = WIDTH/BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX   = ACC_W'(PW);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     a_shift;
  logic [WIDTH-1:0]  b_shift;
  logic [PW-1:0]     accum;
  logic [PW-1:0]     product_q;
  logic              neg_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  step;

  logic [WIDTH-1:0]  mag_a_in;
  logic [WIDTH-1:0]  mag_b_in;
  logic              neg_in;
  logic [ACC_W-1:0]  acc_in;

  logic [PW-1:0]     trunc_mask;
  logic [PW-1:0]     step_sum;
  logic [PW-1:0]     comp;
  logic [PW-1:0]     final_sum;
  logic [PW-1:0]     final_res;

  assign mag_a_in = (signed_a && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign mag_b_in = (signed_b && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign neg_in   = (signed_a & multiplicand[WIDTH-1]) ^ (signed_b & multiplier[WIDTH-1]);
  assign acc_in   = (acc > ACC_MAX) ? ACC_MAX : acc;

  // a_shift/b_shift advance each step, so bit j of b_shift always pairs with a_shift << j.
  always_comb begin
    trunc_mask = {PW{1'b1}} << acc_q;
    step_sum   = accum;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_shift[j]) begin
        step_sum = step_sum + ((a_shift << j) & trunc_mask);
      end
    end
    comp      = (acc_q != '0) ? (PW'(1) << (acc_q - 1'b1)) : '0;
    final_sum = step_sum + comp;
    final_res = neg_q ? -final_sum : final_sum;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_shift   <= '0;
      b_shift   <= '0;
      accum     <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      step      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_shift   <= PW'(mag_a_in);
            b_shift   <= mag_b_in;
            neg_q     <= neg_in;
            acc_q     <= acc_in;
            step      <= '0;
            accum     <= '0;
            product_q <= '0;
            state     <= (mag_a_in == '0 || mag_b_in == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          accum   <= step_sum;
          a_shift <= a_shift << BITS_PER_CYCLE;
          b_shift <= b_shift >> BITS_PER_CYCLE;
          step    <= step + 1'b1;
          if (step == LAST_STEP) begin
            product_q <= final_res;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_approx_seq_multiply_unit.sv
// Randomized and directed bench for approx_seq_multiply_unit against an arithmetic reference model.
module tb_approx_seq_multiply_unit;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        signed_a;
  logic        signed_b;
  logic [6:0]  acc;
  logic [63:0] product;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  approx_seq_multiply_unit dut (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .signed_a(signed_a), .signed_b(signed_b), .acc(acc),
    .product(product), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mag64(input logic [31:0] v, input logic s);
    logic [31:0] t;
    t = (s && v[31]) ? -v : v;
    return {32'b0, t};
  endfunction

  // Sum of every set multiplier column's partial, low acc columns dropped, plus half-ULP.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb, input logic [6:0] ac);
    logic [63:0] ma, mb, sum, mask;
    int k;
    logic neg;
    k    = (ac > 7'd64) ? 64 : int'(ac);
    ma   = mag64(a, sa);
    mb   = mag64(b, sb);
    neg  = (sa & a[31]) ^ (sb & b[31]);
    if (ma == 0 || mb == 0) return 64'd0;
    mask = ~64'd0 << k;
    sum  = 64'd0;
    for (int i = 0; i < 32; i++) begin
      if (mb[i]) sum = sum + ((ma << i) & mask);
    end
    if (k > 0) sum = sum + (64'd1 << (k - 1));
    return neg ? -sum : sum;
  endfunction

  function automatic logic [63:0] exact(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic [63:0] ae, be;
    ae = sa ? {{32{a[31]}}, a} : {32'b0, a};
    be = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ae * be;
  endfunction

  // Latency is counted in edges after the accepting edge; zero operands land in DONE on that edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                        input logic [6:0] ac, input int hold, input string tag);
    logic [63:0] exp;
    int lat, exp_lat;
    exp     = model(a, b, sa, sb, ac);
    exp_lat = (mag64(a, sa) == 0 || mag64(b, sb) == 0) ? 0 : 8;
    @(negedge CLK);
    multiplicand = a; multiplier = b; signed_a = sa; signed_b = sb; acc = ac;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    multiplicand = $urandom; multiplier = $urandom; acc = 7'($urandom);
    signed_a = 1'($urandom); signed_b = 1'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_prod"}, product, exp);
    if (ac == 7'd0) check({tag, "_exact"}, product, exact(a, b, sa, sb));
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      in_valid = ~in_valid;
      multiplicand = $urandom; multiplier = $urandom;
      @(posedge CLK); #1;
      check({tag, "_hold_prod"}, product, exp);
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
    end
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({tag, "_rel_vld"}, 64'(out_valid), 64'd0);
    check({tag, "_rel_rdy"}, 64'(in_ready), 64'd1);
    check({tag, "_rel_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0; signed_a = 1'b0; signed_b = 1'b0; acc = '0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge CLK);
    reset_n = 1'b1;

    run_op(32'h0D0D0D0D, 32'h15151515, 1'b0, 1'b0, 7'd0, 0, "exact_u");
    check("exact_u_const", product, 64'h0111_2233_2211_0011 * 0 + exact(32'h0D0D0D0D, 32'h15151515, 1'b0, 1'b0));
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 7'd2, 0, "trunc_3x5");
    check("trunc_3x5_val", model(32'd3, 32'd5, 1'b0, 1'b0, 7'd2), 64'd14);
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 7'd0, 0, "neg3x5");
    check("neg3x5_val", model(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 7'd0), 64'hFFFFFFFFFFFFFFF1);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 7'd0, 0, "minsq");
    check("minsq_val", model(32'h80000000, 32'h80000000, 1'b1, 1'b1, 7'd0), 64'h4000000000000000);
    run_op(32'd0, 32'h12345678, 1'b0, 1'b0, 7'd10, 0, "zero_a");
    run_op(32'd1, 32'd1, 1'b0, 1'b0, 7'd127, 0, "clamp");
    check("clamp_val", model(32'd1, 32'd1, 1'b0, 1'b0, 7'd127), 64'h8000000000000000);
    run_op(32'h1234ABCD, 32'h0F0F7777, 1'b1, 1'b0, 7'd20, 5, "stall");

    // Reset mid-calculation, four steps in.
    @(negedge CLK);
    multiplicand = 32'h7654321F; multiplier = 32'h0BADF00D; signed_a = 1'b0; signed_b = 1'b0; acc = 7'd0;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_product", product, 64'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    run_op(32'h7654321F, 32'h0BADF00D, 1'b0, 1'b0, 7'd0, 0, "post_rst");

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, b;
      logic [6:0]  ac;
      a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      ac = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      run_op(a, b, 1'($urandom), 1'($urandom), ac, $urandom_range(0, 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_seq_multiply_unit.md
APPROX_SEQ_MULTIPLY_UNIT -- requirements
Module: approx_seq_multiply_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; product is 2*WIDTH bits.
REQ-002 Parameter BITS_PER_CYCLE, default 4: multiplier bits consumed per CALC cycle; SHALL divide WIDTH; STEPS = WIDTH/BITS_PER_CYCLE.
REQ-003 Parameter ACC_W, default $clog2(2*WIDTH)+1 (7 for WIDTH=32): width of accuracy control.
REQ-004 CLK  input  1  rising-edge clock; one clock domain only.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  unit can accept a request (high only in IDLE).
REQ-008 multiplicand, multiplier  input  WIDTH each  operands.
REQ-009 signed_a, signed_b  input  1 each  treat the corresponding operand as two's complement.
REQ-010 acc  input  ACC_W  number of truncated low product columns; 0 = exact.
REQ-011 product  output  2*WIDTH  result, valid while out_valid.
REQ-012 out_valid  output  1  result available; out_ready  input  1  consumer accepts.
REQ-013 busy  output  1  high in CALC and DONE.

Function
REQ-014 States IDLE, CALC, DONE; transfer in = in_valid & in_ready at a rising edge; transfer out = out_valid & out_ready at a rising edge.
REQ-015 On transfer in: latch operands, signed_a/b, acc; form magnitudes |A|,|B| (unsigned operands unchanged); neg = (signed_a & A[W-1]) ^ (signed_b & B[W-1]).
REQ-016 acc values > 2*WIDTH SHALL be clamped to 2*WIDTH at latch time.
REQ-017 If |A|==0 or |B|==0: go directly to DONE with product 0, no compensation; out_valid high after exactly 1 edge.
REQ-018 Otherwise go to CALC with step counter 0 and accumulator 0.
REQ-019 Each CALC cycle processes BITS_PER_CYCLE multiplier bits i (LSB first): accumulator += sum over those i with |B|[i]=1 of ((|A| << i) with bits below column acc cleared).
REQ-020 In the final CALC cycle (counter = STEPS-1), add compensation 1<<(acc-1) when acc>0, then apply two's-complement negation of the 2*WIDTH result if neg, and go to DONE.
REQ-021 Latency: out_valid rises after exactly STEPS edges following transfer in (8 for defaults); no early termination.
REQ-022 Arithmetic is modulo 2^(2*WIDTH); with acc=0 product SHALL equal the exact signed/unsigned product per the signed_a/signed_b mode.
REQ-023 DONE: out_valid=1, product held stable until transfer out; then IDLE, in_ready=1 the following cycle.
REQ-024 in_valid while not in IDLE is ignored; operand/acc changes after transfer in have no effect.
REQ-025 No back-to-back accept in the same cycle as transfer out (one cycle of IDLE minimum).

Reset
REQ-026 reset_n low, at any time including mid-CALC or in DONE, SHALL immediately force IDLE, counter 0, accumulator 0, product 0, out_valid 0, busy 0, in_ready 1; in-flight operation discarded.
REQ-027 First transfer in is possible on the first rising edge with reset_n high.

Verification (WIDTH=32, BITS_PER_CYCLE=4)
REQ-028 A=0x0D0D0D0D, B=0x15151515, unsigned, acc=0 -> after 8 edges out_valid=1, product = exact 64-bit A*B.
REQ-029 A=3, B=5, unsigned, acc=2 -> product = 14 (12 from truncated partials + compensation 2).
REQ-030 A=0xFFFFFFFD signed, B=5 unsigned, acc=0 -> product = 0xFFFFFFFFFFFFFFF1 (-15); A=0x80000000 signed, B=0x80000000 signed -> 0x4000000000000000.
REQ-031 A=0, B=0x12345678, acc=10 -> product 0, out_valid after 1 edge; acc=127 with A=B=1 -> clamped to 64, product 0x8000000000000000.
REQ-032 out_ready held low 5 cycles in DONE with in_valid toggling -> product stable, in_ready=0, no new capture; out_ready high -> IDLE next cycle.
REQ-033 reset_n pulsed low at CALC step 4 -> all outputs reset values asynchronously; next request completes normally in 8 edges.
